fixed_dot_acc: RTL and testbench



---
 rtl/fixed_dot_acc.sv | 146 ++++++++++++++
 tb/tb_fixed_dot_acc.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_dot_acc.sv
// fixed_dot_acc: streaming sign-magnitude fixed-point dot product.
// One element pair per cycle is multiplied (stage 1) and accumulated
// (stage 2); one saturating sign-magnitude result is emitted per vector.
module fixed_dot_acc #(
  parameter int WL  = 32,
  parameter int IWL = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WL-1:0] in_a,
  input  logic [WL-1:0] in_b,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WL-1:0] out_data,
  output logic          out_ovf
);

  localparam int FWL = WL - IWL;
  localparam int MW  = WL - 1;                  // magnitude width
  localparam logic [MW-1:0] MAG_MAX = '1;

  typedef enum logic [1:0] {
    ACC,
    FLUSH,
    OUT
  } state_t;

  state_t state;

  // Stage 1 product register
  logic          p_valid;
  logic          p_sign;
  logic [MW-1:0] p_mag;
  logic          p_ovf;

  // Stage 2 accumulator register
  logic          acc_sign;
  logic [MW-1:0] acc_mag;
  logic          ovf;

  logic accept;

  // Combinational multiply of the incoming pair
  logic [2*MW-1:0] full_prod;
  logic [2*MW-1:0] prod_shift;
  logic            prod_sat;
  logic [MW-1:0]   prod_mag;
  logic            prod_sign;

  // Combinational next accumulator value
  logic [MW:0]   sum_mag;
  logic          nxt_sign;
  logic [MW-1:0] nxt_mag;
  logic          add_ovf;

  assign accept    = in_valid && (state == ACC);
  assign in_ready  = (state == ACC);
  assign out_valid = (state == OUT);
  assign out_data  = {acc_sign, acc_mag};
  assign out_ovf   = ovf;

  // Multiply magnitudes, drop FWL fraction bits, saturate, and suppress -0
  always_comb begin
    full_prod  = (2*MW)'(in_a[MW-1:0]) * (2*MW)'(in_b[MW-1:0]);
    prod_shift = full_prod >> FWL;
    prod_sat   = |prod_shift[2*MW-1:MW];
    prod_mag   = prod_sat ? MAG_MAX : prod_shift[MW-1:0];
    prod_sign  = (in_a[WL-1] ^ in_b[WL-1]) && (prod_mag != '0);
  end

  // Sign-magnitude add of the registered product into the accumulator
  // NOTE: every output gets a default first so no path leaves a value held,
  // which would otherwise infer a latch.
  always_comb begin
    sum_mag  = {1'b0, acc_mag} + {1'b0, p_mag};
    nxt_sign = acc_sign;
    nxt_mag  = acc_mag;
    add_ovf  = 1'b0;
    if (acc_sign == p_sign) begin
      if (sum_mag[MW]) begin
        nxt_mag = MAG_MAX;
        add_ovf = 1'b1;
      end else begin
        nxt_mag = sum_mag[MW-1:0];
      end
    end else if (acc_mag >= p_mag) begin
      nxt_mag = acc_mag - p_mag;
    end else begin
      nxt_mag  = p_mag - acc_mag;
      nxt_sign = p_sign;
    end
    if (nxt_mag == '0) nxt_sign = 1'b0;
  end

  // Control FSM, product stage and accumulator stage
  // NOTE: all state here updates with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ACC;
      p_valid  <= 1'b0;
      p_sign   <= 1'b0;
      p_mag    <= '0;
      p_ovf    <= 1'b0;
      acc_sign <= 1'b0;
      acc_mag  <= '0;
      ovf      <= 1'b0;
    end else begin
      p_valid <= accept;
      if (accept) begin
        p_sign <= prod_sign;
        p_mag  <= prod_mag;
        p_ovf  <= prod_sat;
      end

      if (p_valid) begin
        acc_sign <= nxt_sign;
        acc_mag  <= nxt_mag;
        ovf      <= ovf | p_ovf | add_ovf;
      end

      case (state)
        ACC: begin
          if (accept && in_last) state <= FLUSH;
        end
        FLUSH: begin
          // Wait until the last product has drained into the accumulator
          if (!p_valid) state <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            state    <= ACC;
            acc_sign <= 1'b0;
            acc_mag  <= '0;
            ovf      <= 1'b0;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_dot_acc.sv
// Testbench for fixed_dot_acc: directed and random vectors checked by a
// scoreboard fed from a signed-integer reference model.
module tb_fixed_dot_acc;

  localparam longint MAXV = 64'h7FFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_ovf;

  fixed_dot_acc #(.WL(32), .IWL(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ovf  (out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        ovf;
  } res_t;

  res_t        sb[$];
  logic [31:0] va[$];
  logic [31:0] vb[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: real-valued dot product in signed integers, clamped to the
  // representable range after every product and every partial sum.
  task automatic model(output res_t e);
    longint acc;
    longint p;
    acc   = 0;
    e.ovf = 1'b0;
    for (int i = 0; i < va.size(); i++) begin
      p = (longint'(va[i][30:0]) * longint'(vb[i][30:0])) / (64'sd1 << 24);
      if (p > MAXV) begin
        p     = MAXV;
        e.ovf = 1'b1;
      end
      if (va[i][31] != vb[i][31]) p = -p;
      acc = acc + p;
      if (acc > MAXV) begin
        acc   = MAXV;
        e.ovf = 1'b1;
      end else if (acc < -MAXV) begin
        acc   = -MAXV;
        e.ovf = 1'b1;
      end
    end
    if (acc < 0) e.d = {1'b1, 31'(-acc)};
    else         e.d = {1'b0, 31'(acc)};
  endtask

  // Monitor: compare each result on the cycle its handshake completes
  always @(negedge clk) begin
    res_t e;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_result: got 0x%08h expected none", out_data);
      end else begin
        e = sb.pop_front();
        check("out_data", out_data, e.d);
        check("out_ovf", 32'(out_ovf), 32'(e.ovf));
      end
    end
  end

  // Send the vector in va/vb, then check latency, backpressure and release
  task automatic run_vec(input bit bubbles, input int hold);
    res_t e;
    int   cyc;
    int   guard;
    logic rdy;
    model(e);
    sb.push_back(e);
    out_ready = (hold == 0);
    guard     = 0;
    for (int i = 0; i < va.size() && guard < 200; guard++) begin
      if (bubbles && $urandom_range(0, 1) == 1) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_a     = va[i];
        in_b     = vb[i];
        in_last  = (i == va.size() - 1);
      end
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (in_valid && rdy) i++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 10) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("latency", 32'(cyc), 32'd2);
    if (hold > 0) begin
      repeat (hold) begin
        check("bp_ready", 32'(in_ready), 32'd0);
        check("bp_valid", 32'(out_valid), 32'd1);
        check("bp_data", out_data, e.d);
        check("bp_ovf", 32'(out_ovf), 32'(e.ovf));
        @(posedge clk);
        #1;
      end
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    check("ready_return", 32'(in_ready), 32'd1);
    check("valid_drop", 32'(out_valid), 32'd0);
    out_ready = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_data"}, out_data, 32'd0);
    check({tag, "_out_ovf"}, 32'(out_ovf), 32'd0);
  endtask

  function automatic logic [31:0] rand_elem();
    logic [30:0] m;
    m = 31'($urandom) >> $urandom_range(3, 14);
    if ($urandom_range(0, 15) == 0) m = 31'($urandom);
    return {1'($urandom), m};
  endfunction

  initial begin
    int n;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle("reset");

    // Single element: 1.5 * 2.0
    va = {32'h0180_0000};
    vb = {32'h0200_0000};
    run_vec(1'b0, 0);

    // Three elements: 1 - 0.5 - 1 = -0.5
    va = {32'h0100_0000, 32'h8100_0000, 32'h0040_0000};
    vb = {32'h0100_0000, 32'h0080_0000, 32'h8400_0000};
    run_vec(1'b0, 0);

    // Exact cancellation must give +0
    va = {32'h0100_0000, 32'h8100_0000};
    vb = {32'h0100_0000, 32'h0100_0000};
    run_vec(1'b0, 0);

    // Product saturation, then a clean vector
    va = {32'h6400_0000};
    vb = {32'h0200_0000};
    run_vec(1'b0, 0);
    va = {32'h0100_0000};
    vb = {32'h0100_0000};
    run_vec(1'b0, 0);

    // Backpressure, then a bubbled vector from a fresh accumulator
    va = {32'h0200_0000, 32'h8080_0000};
    vb = {32'h0300_0000, 32'h0100_0000};
    run_vec(1'b0, 5);
    va = {32'h0100_0000, 32'h0200_0000, 32'h8030_0000};
    vb = {32'h0100_0000, 32'h8020_0000, 32'h8400_0000};
    run_vec(1'b1, 0);

    // Reset mid-vector discards the partial accumulation
    in_valid = 1'b1;
    in_last  = 1'b0;
    in_a     = 32'h0300_0000;
    in_b     = 32'h0300_0000;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle("midrst");
    va = {32'h0080_0000};
    vb = {32'h0080_0000};
    run_vec(1'b0, 0);

    // Random vectors
    for (int v = 0; v < 40; v++) begin
      va.delete();
      vb.delete();
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        va.push_back(rand_elem());
        vb.push_back(rand_elem());
      end
      run_vec(1'($urandom), $urandom_range(0, 2));
    end

    repeat (3) @(posedge clk);
    #1;
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
